corr_scan_scheduler: RTL and testbench
======================================

Name: corr_scan_scheduler

Overview:
- Sequences the correlation engine over a rectangular search window of the saved frame, one (X,Y) candidate at a time, using a start/done handshake.
- Tracks the peak correlation and its coordinates, then reports a one-cycle result-valid pulse.
- Sits between the frame-save logic (frame-done flag), the correlation datapath (start/done/value) and the result consumers (overlay, LEDs).

Parameters:
- H_RES, 640, frame width in pixels; X is clamped to H_RES-1.
- V_RES, 480, frame height in pixels; Y is clamped to V_RES-1.
- COORD_W, 13, coordinate width.
- CORR_W, 32, correlation value width.
- LED_DIV, 22, the heartbeat toggles every 2^LED_DIV clocks while busy.
- TIMEOUT, 4096, watchdog cycles per point (used only with the optional feature).

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRST_N  in  1  synchronous active-low reset.
- iFrameDone  in  1  frame saved; a 0->1 edge starts a scan.
- iAbort  in  1  synchronous abort.
- iXmin, iXmax, iYmin, iYmax  in  COORD_W  search window, inclusive; latched at start.
- iStep  in  4  scan stride; 0 is treated as 1; latched at start.
- iCorrDone  in  1  single-cycle pulse: correlation for the current point is finished.
- iCurrentCorr  in  CORR_W  correlation value; valid with iCorrDone.
- oCorrStart  out  1  one-cycle pulse to launch a point.
- oX, oY  out  COORD_W  current point; stable from oCorrStart until iCorrDone.
- oBusy  out  1  scan in progress.
- oResultValid  out  1  one-cycle pulse at scan end.
- oXresult, oYresult  out  COORD_W  peak coordinates.
- oPeakCorr  out  CORR_W  peak value.
- oPointCount  out  20  points evaluated in the last or current scan.
- oEmpty  out  1  the last scan had an empty window.
- oStatusLed  out  1  heartbeat.

Behaviour:
- Reset (iRST_N=0 at a clock edge): every output is 0, state is IDLE, and the iFrameDone edge-detect register is cleared. Reset overrides all other inputs.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE -> ISSUE:
  - Triggered by an iFrameDone 0->1 edge, using a registered previous value.
  - Edges seen in any other state are ignored.
  - On the start cycle, latch the window and step.
  - Clamp xmax to min(iXmax, H_RES-1) and ymax to min(iYmax, V_RES-1).
  - Set oX=xmin, oY=ymin, oPointCount=0, oEmpty=0, oBusy=1.
  - If xmin>xmax or ymin>ymax after clamping, go directly to DONE with oEmpty=1 and oXresult, oYresult and oPeakCorr all 0.
- ISSUE: assert oCorrStart for exactly 1 cycle, then go to WAIT.
- WAIT: iCorrDone pulses seen in ISSUE, IDLE or DONE are ignored. On iCorrDone:
  - Increment oPointCount, saturating at all-ones.
  - Peak update: if this is the first point of the scan, or iCurrentCorr > oPeakCorr (strictly greater, unsigned, so the earliest point wins ties), load oPeakCorr, oXresult and oYresult.
  - Advance: compute nx = oX + step in COORD_W+1 bits, so there is no wrap.
    - If nx <= xmax, set oX=nx.
    - Otherwise set oX=xmin and compute ny = oY + step (COORD_W+1 bits).
    - If ny > ymax, go to DONE; otherwise set oY=ny.
  - Go to ISSUE on the next cycle.
  - Minimum of 2 cycles per point: ISSUE, then WAIT with immediate done.
- DONE:
  - Pulse oResultValid for 1 cycle, clear oBusy, go to IDLE.
  - oXresult, oYresult and oPeakCorr hold until the next start.
  - oX and oY hold their last values.
- iAbort=1 in any non-IDLE state:
  - Next state is IDLE and oBusy=0.
  - No oResultValid pulse; the result registers keep their pre-scan values.
  - A pending iCorrDone in that cycle is discarded.
- Simultaneous iAbort and start edge in IDLE: abort wins and the scan does not start.
- oStatusLed toggles when a free-running LED_DIV-bit counter wraps, only while oBusy=1; it holds its value when idle.
- A 1x1 window gives one point, and oResultValid carries that point's coordinates and value.

Optional Feature:
- Macro SCAN_TIMEOUT_EN.
- When defined:
  - A watchdog counter is cleared on oCorrStart and counts in WAIT.
  - Reaching TIMEOUT is treated as a done with value 0, but that value never updates the peak, including on the first point.
  - The counter then advances to the next point.
  - The sticky output oTimeoutErr (1 bit) is set and is cleared only at the next scan start or on reset.
- When not defined: WAIT has no time limit and the port oTimeoutErr is absent.

Test Plan:
- Window X 0..3, Y 0..2, step 1; corr = 10*X+Y, done 3 cycles after each start -> 12 oCorrStart pulses in raster order; oResultValid with Xresult=3, Yresult=2, Peak=32, PointCount=12.
- Window X 10..20, Y 5..9, step 4; all corr=7 -> points X{10,14,18} by Y{5,9}, PointCount=6; tie keeps the first point, so Xresult=10, Yresult=5, Peak=7.
- iXmax=700, iYmax=500, xmin=636, ymin=478, step 2 -> X clamps to 639, giving points X{636,638} by Y{478}, PointCount=2; no wrap past H_RES-1.
- iXmin=5, iXmax=4 -> oResultValid 2 cycles after the edge, oEmpty=1, results 0, no oCorrStart.
- Abort during the 3rd WAIT of the first scenario -> oBusy drops the next cycle, no oResultValid, previous results retained; a new iFrameDone edge restarts cleanly at (0,0).
- With SCAN_TIMEOUT_EN and TIMEOUT=16, omit iCorrDone on point 2 -> the scan continues after 16 cycles, oTimeoutErr=1, and the peak excludes point 2.

Source files
------------

// File: rtl/corr_scan_scheduler_if.sv
// Bundle between the scan scheduler and its environment: frame trigger, window config,
// correlation engine handshake and result outputs. SCAN_TIMEOUT_EN adds o_timeout_err.
interface corr_scan_scheduler_if #(
  parameter int COORD_W = 13,
  parameter int CORR_W  = 32
);
  logic               i_frame_done;
  logic               i_abort;
  logic [COORD_W-1:0] i_xmin;
  logic [COORD_W-1:0] i_xmax;
  logic [COORD_W-1:0] i_ymin;
  logic [COORD_W-1:0] i_ymax;
  logic [3:0]         i_step;
  logic               i_corr_done;
  logic [CORR_W-1:0]  i_current_corr;

  logic               o_corr_start;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_busy;
  logic               o_result_valid;
  logic [COORD_W-1:0] o_xresult;
  logic [COORD_W-1:0] o_yresult;
  logic [CORR_W-1:0]  o_peak_corr;
  logic [19:0]        o_point_count;
  logic               o_empty;
  logic               o_status_led;
`ifdef SCAN_TIMEOUT_EN
  logic               o_timeout_err;
`endif

  modport slave (
    input  i_frame_done, i_abort, i_xmin, i_xmax, i_ymin, i_ymax, i_step,
           i_corr_done, i_current_corr,
    output o_corr_start, o_x, o_y, o_busy, o_result_valid, o_xresult, o_yresult,
           o_peak_corr, o_point_count, o_empty, o_status_led
`ifdef SCAN_TIMEOUT_EN
    , output o_timeout_err
`endif
  );

  modport master (
    output i_frame_done, i_abort, i_xmin, i_xmax, i_ymin, i_ymax, i_step,
           i_corr_done, i_current_corr,
    input  o_corr_start, o_x, o_y, o_busy, o_result_valid, o_xresult, o_yresult,
           o_peak_corr, o_point_count, o_empty, o_status_led
`ifdef SCAN_TIMEOUT_EN
    , input o_timeout_err
`endif
  );
endinterface

// File: rtl/corr_scan_scheduler.sv
// Raster-scans a search window through the correlation engine and reports the peak point.
// Optional per-point watchdog enabled by defining SCAN_TIMEOUT_EN.
module corr_scan_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 13,
  parameter int CORR_W  = 32,
  parameter int LED_DIV = 22,
  parameter int TIMEOUT = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  corr_scan_scheduler_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for a frame-done rising edge
  // ISSUE | o_corr_start high for the current point
  // WAIT  | waiting for the engine to finish the current point
  // DONE  | commit peak, result-valid pulses on the way back to IDLE
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("corr_scan_scheduler: TIMEOUT must be at least 1");
  end

  state_t             r_state;
  logic               r_frame_prev;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
  logic [3:0]         r_step;
  logic               r_corr_start;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_busy;
  logic               r_result_valid;
  logic [COORD_W-1:0] r_xres, r_yres;
  logic [CORR_W-1:0]  r_peak;
  logic [19:0]        r_point_cnt;
  logic               r_empty;
  logic               r_led;
  logic [LED_DIV-1:0] r_led_cnt;
  // Running peak lives in shadow registers so an aborted scan leaves the outputs untouched.
  logic               r_first;
  logic [CORR_W-1:0]  r_pk_val;
  logic [COORD_W-1:0] r_pk_x, r_pk_y;

  logic               w_start_edge;
  logic [COORD_W-1:0] w_xmax_c, w_ymax_c;
  logic [3:0]         w_step;
  logic               w_empty;
  logic [COORD_W:0]   w_nx, w_ny;
  logic               w_pt_done;
  logic               w_new_peak;

  assign w_start_edge = bus.i_frame_done & ~r_frame_prev;
  assign w_xmax_c     = (bus.i_xmax > X_LIM) ? X_LIM : bus.i_xmax;
  assign w_ymax_c     = (bus.i_ymax > Y_LIM) ? Y_LIM : bus.i_ymax;
  assign w_step       = (bus.i_step == 4'd0) ? 4'd1 : bus.i_step;
  assign w_empty      = (bus.i_xmin > w_xmax_c) || (bus.i_ymin > w_ymax_c);
  assign w_nx         = {1'b0, r_x} + {{(COORD_W-3){1'b0}}, r_step};
  assign w_ny         = {1'b0, r_y} + {{(COORD_W-3){1'b0}}, r_step};
  assign w_new_peak   = bus.i_corr_done && (r_first || (bus.i_current_corr > r_pk_val));

`ifdef SCAN_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT) + 1;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_err;
  logic              w_wdog_hit;

  assign w_wdog_hit        = (r_wdog == '0) && !bus.i_corr_done;
  assign w_pt_done         = bus.i_corr_done || (r_wdog == '0);
  assign bus.o_timeout_err = r_timeout_err;
`else
  assign w_pt_done = bus.i_corr_done;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_frame_prev   <= 1'b0;
      r_xmin         <= '0;
      r_xmax         <= '0;
      r_ymax         <= '0;
      r_step         <= '0;
      r_corr_start   <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_xres         <= '0;
      r_yres         <= '0;
      r_peak         <= '0;
      r_point_cnt    <= '0;
      r_empty        <= 1'b0;
      r_led          <= 1'b0;
      r_led_cnt      <= '0;
      r_first        <= 1'b0;
      r_pk_val       <= '0;
      r_pk_x         <= '0;
      r_pk_y         <= '0;
`ifdef SCAN_TIMEOUT_EN
      r_wdog         <= '0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      r_frame_prev   <= bus.i_frame_done;
      r_corr_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_led_cnt      <= r_led_cnt + LED_DIV'(1);
      if (r_busy && (&r_led_cnt)) r_led <= ~r_led;
`ifdef SCAN_TIMEOUT_EN
      if ((r_state == WAIT) && (r_wdog != '0)) r_wdog <= r_wdog - WDOG_W'(1);
`endif
      if (bus.i_abort && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_edge && !bus.i_abort) begin
              r_xmin      <= bus.i_xmin;
              r_xmax      <= w_xmax_c;
              r_ymax      <= w_ymax_c;
              r_step      <= w_step;
              r_x         <= bus.i_xmin;
              r_y         <= bus.i_ymin;
              r_point_cnt <= '0;
              r_busy      <= 1'b1;
              r_first     <= 1'b1;
              r_pk_val    <= '0;
              r_pk_x      <= '0;
              r_pk_y      <= '0;
`ifdef SCAN_TIMEOUT_EN
              r_timeout_err <= 1'b0;
`endif
              if (w_empty) begin
                r_state <= DONE;
                r_empty <= 1'b1;
                r_xres  <= '0;
                r_yres  <= '0;
                r_peak  <= '0;
              end else begin
                r_state      <= ISSUE;
                r_empty      <= 1'b0;
                r_corr_start <= 1'b1;
              end
            end
          end
          ISSUE: begin
            r_state <= WAIT;
`ifdef SCAN_TIMEOUT_EN
            r_wdog  <= WDOG_W'(TIMEOUT - 1);
`endif
          end
          WAIT: begin
            if (w_pt_done) begin
              if (r_point_cnt != '1) r_point_cnt <= r_point_cnt + 20'd1;
              if (w_new_peak) begin
                r_pk_val <= bus.i_current_corr;
                r_pk_x   <= r_x;
                r_pk_y   <= r_y;
                r_first  <= 1'b0;
              end
`ifdef SCAN_TIMEOUT_EN
              if (w_wdog_hit) r_timeout_err <= 1'b1;
`endif
              if (w_nx <= {1'b0, r_xmax}) begin
                r_x          <= w_nx[COORD_W-1:0];
                r_state      <= ISSUE;
                r_corr_start <= 1'b1;
              end else begin
                r_x <= r_xmin;
                if (w_ny > {1'b0, r_ymax}) begin
                  r_state <= DONE;
                end else begin
                  r_y          <= w_ny[COORD_W-1:0];
                  r_state      <= ISSUE;
                  r_corr_start <= 1'b1;
                end
              end
            end
          end
          DONE: begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
            r_xres         <= r_pk_x;
            r_yres         <= r_pk_y;
            r_peak         <= r_pk_val;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_corr_start   = r_corr_start;
  assign bus.o_x            = r_x;
  assign bus.o_y            = r_y;
  assign bus.o_busy         = r_busy;
  assign bus.o_result_valid = r_result_valid;
  assign bus.o_xresult      = r_xres;
  assign bus.o_yresult      = r_yres;
  assign bus.o_peak_corr    = r_peak;
  assign bus.o_point_count  = r_point_cnt;
  assign bus.o_empty        = r_empty;
  assign bus.o_status_led   = r_led;

endmodule

// File: tb/tb_corr_scan_scheduler.sv
// Bench for corr_scan_scheduler: vector table of scan windows, point-order scoreboard,
// plus hand sequences for abort, abort-vs-start and the heartbeat LED.
`timescale 1ns/1ps
module tb_corr_scan_scheduler;
  localparam int COORD_W = 13;
  localparam int CORR_W  = 32;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int LED_DIV = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    int xmin; int xmax; int ymin; int ymax; int step;
    int mode; int dly; int skip;
    int exp_cnt; int exp_x; int exp_y; int exp_peak; int exp_empty;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  corr_scan_scheduler_if #(.COORD_W(COORD_W), .CORR_W(CORR_W)) bus ();

  corr_scan_scheduler #(
    .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .CORR_W(CORR_W),
    .LED_DIV(LED_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int   n_pass = 0;
  int   n_total = 0;
  int   qx[$];
  int   qy[$];
  vec_t vecs[$];
  int   last_x, last_y, last_peak;
  int   led_toggles;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int corr_of(input int mode, input int x, input int y);
    case (mode)
      0:       return 10 * x + y;
      1:       return 7;
      default: return 1000 - 10 * x - y;
    endcase
  endfunction

  // Reference raster order after clamping; pushes every point the scan should issue.
  task automatic build_model(input vec_t v);
    int xm, ym, st;
    qx.delete();
    qy.delete();
    xm = (v.xmax > H_RES - 1) ? H_RES - 1 : v.xmax;
    ym = (v.ymax > V_RES - 1) ? V_RES - 1 : v.ymax;
    st = (v.step == 0) ? 1 : v.step;
    for (int y = v.ymin; y <= ym; y += st)
      for (int x = v.xmin; x <= xm; x += st) begin
        qx.push_back(x);
        qy.push_back(y);
      end
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int pend, idx, cur, nexp, px, py;
    bit got, led_prev;
    build_model(v);
    nexp = qx.size();
    bus.i_xmin = COORD_W'(v.xmin);
    bus.i_xmax = COORD_W'(v.xmax);
    bus.i_ymin = COORD_W'(v.ymin);
    bus.i_ymax = COORD_W'(v.ymax);
    bus.i_step = 4'(v.step);
    bus.i_frame_done = 1'b1;
    pend = 0; idx = 0; cur = 0; got = 1'b0;
    led_prev = bus.o_status_led;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check({tag, "_busy_start"}, longint'(bus.o_busy), 1);
      if (bus.o_status_led != led_prev) led_toggles++;
      led_prev = bus.o_status_led;
      bus.i_corr_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.i_corr_done    = 1'b1;
          bus.i_current_corr = CORR_W'(cur);
        end
      end
      if (bus.o_corr_start) begin
        if (qx.size() == 0) begin
          check({tag, "_start_count"}, longint'(idx + 1), longint'(nexp));
        end else begin
          px = qx.pop_front();
          py = qy.pop_front();
          check({tag, "_pt_x"}, longint'(bus.o_x), longint'(px));
          check({tag, "_pt_y"}, longint'(bus.o_y), longint'(py));
          cur = corr_of(v.mode, px, py);
          if (idx != v.skip) pend = v.dly;
          idx++;
        end
      end
      if (bus.o_result_valid) begin
        got = 1'b1;
        check({tag, "_busy_end"}, longint'(bus.o_busy), 0);
        check({tag, "_count"}, longint'(bus.o_point_count), longint'(v.exp_cnt));
        check({tag, "_xres"}, longint'(bus.o_xresult), longint'(v.exp_x));
        check({tag, "_yres"}, longint'(bus.o_yresult), longint'(v.exp_y));
        check({tag, "_peak"}, longint'(bus.o_peak_corr), longint'(v.exp_peak));
        check({tag, "_empty"}, longint'(bus.o_empty), longint'(v.exp_empty));
`ifdef SCAN_TIMEOUT_EN
        check({tag, "_timeout_err"}, longint'(bus.o_timeout_err), longint'(v.skip >= 0));
`endif
      end
    end
    check({tag, "_result_seen"}, longint'(got), 1);
    check({tag, "_unissued"}, longint'(qx.size()), 0);
    bus.i_corr_done  = 1'b0;
    bus.i_frame_done = 1'b0;
    @(negedge clk);
    check({tag, "_rv_one_cycle"}, longint'(bus.o_result_valid), 0);
    @(negedge clk);
    last_x    = v.exp_x;
    last_y    = v.exp_y;
    last_peak = v.exp_peak;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int  starts, pend, hits, chg;
    bit  aborted, led_prev;

    bus.i_frame_done   = 1'b0;
    bus.i_abort        = 1'b0;
    bus.i_xmin         = '0;
    bus.i_xmax         = '0;
    bus.i_ymin         = '0;
    bus.i_ymax         = '0;
    bus.i_step         = 4'd1;
    bus.i_corr_done    = 1'b0;
    bus.i_current_corr = '0;
    led_toggles        = 0;

    //                xmin xmax ymin ymax step mode dly skip  cnt  x    y    peak  empty
    vecs.push_back('{   0,   3,   0,   2,   1,   0,  3,  -1,  12,   3,   2,   32,  0});
    vecs.push_back('{  10,  20,   5,   9,   4,   1,  1,  -1,   6,  10,   5,    7,  0});
    vecs.push_back('{ 636, 700, 478, 500,   2,   0,  1,  -1,   2, 638, 478, 6858,  0});
    vecs.push_back('{   5,   4,   0,   0,   1,   0,  1,  -1,   0,   0,   0,    0,  1});
    vecs.push_back('{   2,   3,   1,   1,   0,   0,  2,  -1,   2,   3,   1,   31,  0});
    vecs.push_back('{   7,   7,   9,   9,   3,   0,  1,  -1,   1,   7,   9,   79,  0});
    vecs.push_back('{ 650, 700,   0,   0,   1,   0,  1,  -1,   0,   0,   0,    0,  1});
    vecs.push_back('{   0,   1,   3,   2,   1,   0,  1,  -1,   0,   0,   0,    0,  1});
    vecs.push_back('{   0,   2,   0,   1,   1,   2,  1,  -1,   6,   0,   0, 1000,  0});
`ifdef SCAN_TIMEOUT_EN
    vecs.push_back('{   0,   2,   0,   0,   1,   0,  1,   2,   3,   1,   0,   10,  0});
`endif

    // Reset with a frame-done level present: nothing may start.
    bus.i_frame_done = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_corr_start", longint'(bus.o_corr_start), 0);
    check("rst_busy", longint'(bus.o_busy), 0);
    check("rst_result_valid", longint'(bus.o_result_valid), 0);
    check("rst_point_count", longint'(bus.o_point_count), 0);
    check("rst_peak", longint'(bus.o_peak_corr), 0);
    check("rst_x", longint'(bus.o_x), 0);
    check("rst_led", longint'(bus.o_status_led), 0);
    bus.i_frame_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Heartbeat must hold while idle.
    chg = 0;
    led_prev = bus.o_status_led;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_status_led != led_prev) chg++;
      led_prev = bus.o_status_led;
    end
    check("led_idle_hold", longint'(chg), 0);
    check("idle_busy", longint'(bus.o_busy), 0);

    for (int i = 0; i < vecs.size(); i++) run_scan(vecs[i], $sformatf("v%0d", i));
    check("led_toggled_busy", longint'(led_toggles > 0), 1);

    // Abort in the third WAIT of the 4x3 scan, with a done pending in the same cycle.
    bus.i_xmin = 13'd0; bus.i_xmax = 13'd3;
    bus.i_ymin = 13'd0; bus.i_ymax = 13'd2;
    bus.i_step = 4'd1;
    bus.i_frame_done = 1'b1;
    starts = 0; pend = 0; aborted = 1'b0;
    for (int cyc = 0; cyc < 200 && !aborted; cyc++) begin
      @(negedge clk);
      bus.i_corr_done = 1'b0;
      if (pend > 0) begin
        pend = 0;
        bus.i_corr_done    = 1'b1;
        bus.i_current_corr = 32'd5000;
        if (starts == 3) begin
          bus.i_abort = 1'b1;
          aborted     = 1'b1;
        end
      end
      if (bus.o_corr_start) begin
        starts++;
        pend = 1;
      end
    end
    check("abort_reached", longint'(aborted), 1);
    @(negedge clk);
    bus.i_abort     = 1'b0;
    bus.i_corr_done = 1'b0;
    check("abort_busy_drop", longint'(bus.o_busy), 0);
    check("abort_done_discarded", longint'(bus.o_point_count), 2);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_corr_start || bus.o_result_valid) hits++;
    end
    check("abort_quiet", longint'(hits), 0);
    check("abort_keep_x", longint'(bus.o_xresult), longint'(last_x));
    check("abort_keep_y", longint'(bus.o_yresult), longint'(last_y));
    check("abort_keep_peak", longint'(bus.o_peak_corr), longint'(last_peak));
    bus.i_frame_done = 1'b0;
    repeat (2) @(negedge clk);
    run_scan(vecs[0], "restart");

    // Abort coinciding with a start edge in IDLE: no scan.
    bus.i_frame_done = 1'b1;
    bus.i_abort      = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("abort_vs_start_busy", longint'(bus.o_busy), 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_corr_start || bus.o_busy) hits++;
    end
    check("abort_vs_start_quiet", longint'(hits), 0);
    check("abort_vs_start_peak", longint'(bus.o_peak_corr), longint'(last_peak));
    bus.i_frame_done = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
